// File: rtl/idct_butterfly_out_if.sv
// Handshake bundle for the IDCT output butterfly: pair input side and sample output side.
// The slave modport is the butterfly itself; the master modport is the surrounding pipeline.
interface idct_butterfly_out_if #(
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] e1;
    logic signed [DW-1:0] o1;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] x;
    logic        [2:0]    x_idx;
    logic                 x_last;

    modport slave (
        input  in_valid,
        input  e1,
        input  o1,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x,
        output x_idx,
        output x_last
    );

    modport master (
        output in_valid,
        output e1,
        output o1,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x,
        input  x_idx,
        input  x_last
    );
endinterface

// File: rtl/idct_butterfly_out.sv
// Inverse even/odd butterfly: four (e1,o1) pairs in, eight reconstructed samples out.
// Define IDCT_SAT_EN to saturate results to the signed DW range instead of wrapping.
module idct_butterfly_out #(
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst,
    idct_butterfly_out_if.slave io
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic        [1:0]    pairCnt_q, pairCnt_d;
    logic        [2:0]    xIdx_q, xIdx_d;
    logic signed [DW-1:0] buf_q [8];
    logic signed [DW-1:0] buf_d [8];

    logic signed [DW:0]   sumWide;
    logic signed [DW:0]   diffWide;
    logic                 accept;

    // Reduce a DW+1-bit butterfly result back to DW bits.
    function automatic logic signed [DW-1:0] fitResult(input logic signed [DW:0] v);
`ifdef IDCT_SAT_EN
        if (v[DW] != v[DW-1]) begin
            fitResult = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            fitResult = v[DW-1:0];
        end
`else
        fitResult = v[DW-1:0];
`endif
    endfunction

    assign sumWide  = {io.e1[DW-1], io.e1} + {io.o1[DW-1], io.o1};
    assign diffWide = {io.e1[DW-1], io.e1} - {io.o1[DW-1], io.o1};

    // Outputs are forced idle while rst is high so reset always wins over a handshake.
    assign io.in_ready  = !rst && (state_q == LOAD);
    assign io.out_valid = !rst && (state_q == EMIT);
    assign io.x         = io.out_valid ? buf_q[xIdx_q] : '0;
    assign io.x_idx     = rst ? 3'd0 : xIdx_q;
    assign io.x_last    = io.out_valid && (xIdx_q == 3'd7);

    assign accept = io.in_valid && io.in_ready;

    always_comb begin
        state_d   = state_q;
        pairCnt_d = pairCnt_q;
        xIdx_d    = xIdx_q;
        buf_d     = buf_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    buf_d[{1'b0, pairCnt_q}]         = fitResult(sumWide);
                    buf_d[3'd7 - {1'b0, pairCnt_q}]  = fitResult(diffWide);
                    pairCnt_d                        = pairCnt_q + 2'd1;
                    if (pairCnt_q == 2'd3) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (io.out_ready) begin
                    xIdx_d = xIdx_q + 3'd1;
                    if (xIdx_q == 3'd7) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            pairCnt_q <= 2'd0;
            xIdx_q    <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pairCnt_q <= pairCnt_d;
            xIdx_q    <= xIdx_d;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_idct_butterfly_out.sv
// Directed bench for idct_butterfly_out; expectations follow IDCT_SAT_EN when it is defined.
module tb_idct_butterfly_out;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    idct_butterfly_out_if #(.DW(DW)) bus ();

    idct_butterfly_out #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference for one butterfly output: exact integer math, then clamp or wrap.
    function automatic logic [7:0] modelSample(input int e, input int o, input bit isSum);
        int          v;
        logic [31:0] vb;
        v = isSum ? (e + o) : (e - o);
`ifdef IDCT_SAT_EN
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
`endif
        vb = v;
        return vb[7:0];
    endfunction

    task automatic applyStimulus(input int e, input int o);
        int waitCycles;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.e1       = 8'(e);
        bus.o1       = 8'(o);
        waitCycles   = 0;
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.in_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL pair_accept_timeout in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic resetDut();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.e1        = 8'sd9;
        bus.o1        = 8'sd9;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid got %0b expected 0", bus.out_valid);
        end
        testsRun++;
        if (bus.x !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_x got %0d expected 0", bus.x);
        end
        testsRun++;
        if (bus.x_last !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_x_last got %0b expected 0", bus.x_last);
        end
        testsRun++;
        if (bus.x_idx !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_x_idx got %0d expected 0", bus.x_idx);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready got %0b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [8];
        exp = '{8'd12, 8'd17, 8'd0, 8'd0, 8'd0, 8'hF6, 8'd23, 8'd8};
        resetDut();
        bus.out_ready = 1'b1;
        applyStimulus(10, 2);
        applyStimulus(20, -3);
        applyStimulus(-5, 5);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.e1       = 8'sd0;
        bus.o1       = 8'sd0;
        testsRun++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL basic_before_pair3 out_valid=%0b in_ready=%0b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            testsRun++;
            if (bus.out_valid !== 1'b1 || bus.x !== exp[i] || bus.x_idx !== 3'(i)
                || bus.x_last !== (i == 7)) begin
                testsFailed++;
                $display("[TB] FAIL basic_sample%0d got v=%0b x=%0d idx=%0d last=%0b expected v=1 x=%0d idx=%0d last=%0b",
                         i, bus.out_valid, $signed(bus.x), bus.x_idx, bus.x_last,
                         $signed(exp[i]), i, (i == 7));
            end
            @(negedge clk);
        end
        testsRun++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL basic_back_to_load out_valid=%0b in_ready=%0b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp [8];
        int         waitCycles;
`ifdef IDCT_SAT_EN
        exp = '{8'd127, 8'h80, 8'hFF, 8'd0, 8'd0, 8'd127, 8'd0, 8'd0};
`else
        exp = '{8'hC8, 8'h38, 8'hFF, 8'd0, 8'd0, 8'hFF, 8'd0, 8'd0};
`endif
        resetDut();
        bus.out_ready = 1'b1;
        applyStimulus(100, 100);
        applyStimulus(-100, -100);
        applyStimulus(127, -128);
        applyStimulus(0, 0);
        @(negedge clk);
        waitCycles = 0;
        while (!bus.out_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        for (int i = 0; i < 8; i++) begin
            testsRun++;
            if (bus.out_valid !== 1'b1 || bus.x !== exp[i] || bus.x_idx !== 3'(i)) begin
                testsFailed++;
                $display("[TB] FAIL sat_sample%0d got v=%0b x=%0d idx=%0d expected v=1 x=%0d idx=%0d",
                         i, bus.out_valid, $signed(bus.x), bus.x_idx, $signed(exp[i]), i);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        int waitCycles;
        resetDut();
        bus.out_ready = 1'b1;
        applyStimulus(1, 2);
        applyStimulus(3, 4);
        applyStimulus(5, 6);
        applyStimulus(7, 8);
        @(negedge clk);
        waitCycles = 0;
        while (!(bus.out_valid && bus.x_idx == 3'd3) && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.e1        = 8'sd33;
        bus.o1        = 8'sd44;
        testsRun++;
        if (!(bus.out_valid && bus.x_idx == 3'd3)) begin
            testsFailed++;
            $display("[TB] FAIL hold_reach_idx3 out_valid=%0b x_idx=%0d expected 1/3",
                     bus.out_valid, bus.x_idx);
        end
        for (int c = 0; c < 5; c++) begin
            testsRun++;
            if (bus.x !== 8'd15 || bus.x_idx !== 3'd3 || bus.in_ready !== 1'b0
                || bus.x_last !== 1'b0 || bus.out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL hold_cycle%0d got x=%0d idx=%0d in_ready=%0b last=%0b v=%0b expected x=15 idx=3 in_ready=0 last=0 v=1",
                         c, $signed(bus.x), bus.x_idx, bus.in_ready, bus.x_last, bus.out_valid);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        testsRun++;
        if (bus.x !== 8'd15 || bus.x_idx !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL hold_resume got x=%0d idx=%0d expected x=15 idx=3",
                     $signed(bus.x), bus.x_idx);
        end
        @(negedge clk);
        testsRun++;
        if (bus.x !== 8'hFF || bus.x_idx !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL hold_after_resume got x=%0d idx=%0d expected x=-1 idx=4",
                     $signed(bus.x), bus.x_idx);
        end
        waitCycles = 0;
        while (bus.out_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [8];
        int         waitCycles;
        exp = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        resetDut();
        bus.out_ready = 1'b1;
        applyStimulus(50, 1);
        applyStimulus(60, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1);
        applyStimulus(2, 2);
        applyStimulus(3, 3);
        @(negedge clk);
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midload_no_early_emit out_valid=%0b expected 0", bus.out_valid);
        end
        applyStimulus(4, 4);
        @(negedge clk);
        waitCycles = 0;
        while (!bus.out_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        for (int i = 0; i < 8; i++) begin
            testsRun++;
            if (bus.out_valid !== 1'b1 || bus.x !== exp[i] || bus.x_idx !== 3'(i)) begin
                testsFailed++;
                $display("[TB] FAIL midload_sample%0d got v=%0b x=%0d idx=%0d expected v=1 x=%0d idx=%0d",
                         i, bus.out_valid, $signed(bus.x), bus.x_idx, $signed(exp[i]), i);
            end
            @(negedge clk);
        end

        // Reset in the middle of emission, then confirm only the next block appears.
        bus.out_ready = 1'b0;
        applyStimulus(1, 1);
        applyStimulus(2, 2);
        applyStimulus(3, 3);
        applyStimulus(4, 4);
        @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            testsRun++;
            if (bus.out_valid !== 1'b0 || bus.x_idx !== 3'd0) begin
                testsFailed++;
                $display("[TB] FAIL midemit_idle%0d got v=%0b idx=%0d expected v=0 idx=0",
                         c, bus.out_valid, bus.x_idx);
            end
            @(negedge clk);
        end
        applyStimulus(5, 0);
        applyStimulus(6, 0);
        applyStimulus(7, 0);
        applyStimulus(8, 0);
        @(negedge clk);
        testsRun++;
        if (bus.out_valid !== 1'b1 || bus.x !== 8'd5 || bus.x_idx !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL midemit_new_block got v=%0b x=%0d idx=%0d expected v=1 x=5 idx=0",
                     bus.out_valid, $signed(bus.x), bus.x_idx);
        end
        waitCycles = 0;
        while (bus.out_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
    endtask

    task automatic test_back_to_back();
        int         pe [12];
        int         po [12];
        int         pairIdx;
        int         outCnt;
        int         cycles;
        int         blk;
        int         k;
        int         p;
        logic [7:0] expX;
        for (int i = 0; i < 12; i++) begin
            pe[i] = int'($urandom_range(0, 255)) - 128;
            po[i] = int'($urandom_range(0, 255)) - 128;
        end
        resetDut();
        pairIdx = 0;
        outCnt  = 0;
        cycles  = 0;
        while (outCnt < 24 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (pairIdx < 12 && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.e1       = 8'(pe[pairIdx]);
                bus.o1       = 8'(po[pairIdx]);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                pairIdx++;
            end
            if (bus.in_ready && bus.out_valid) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL b2b_overlap in_ready=1 out_valid=1 expected exclusive");
            end
            if (bus.out_valid && bus.out_ready) begin
                blk  = outCnt / 8;
                k    = outCnt % 8;
                p    = (k < 4) ? k : 7 - k;
                expX = modelSample(pe[blk*4+p], po[blk*4+p], k < 4);
                testsRun++;
                if (bus.x !== expX || bus.x_idx !== 3'(k) || bus.x_last !== (k == 7)) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_sample%0d got x=%0d idx=%0d last=%0b expected x=%0d idx=%0d last=%0b",
                             outCnt, $signed(bus.x), bus.x_idx, bus.x_last, $signed(expX), k, (k == 7));
                end
                outCnt++;
            end
        end
        bus.in_valid = 1'b0;
        testsRun++;
        if (outCnt != 24) begin
            testsFailed++;
            $display("[TB] FAIL b2b_sample_count got %0d expected 24", outCnt);
        end
        @(negedge clk);
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_no_extra out_valid=%0b expected 0", bus.out_valid);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.e1        = '0;
        bus.o1        = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/idct_butterfly_out.md
IDCT_BUTTERFLY_OUT -- requirements
Module: idct_butterfly_out

Interface
REQ-001 Parameter DW, default 8, SHALL set the width of the e1, o1 and x sample buses; the block SHALL treat all three as two's-complement signed values.
REQ-002 clk  input  1  SHALL be the single clock; every register SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 in_valid  input  1  SHALL indicate that the e1/o1 pair on the inputs is valid.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts a pair this cycle.
REQ-006 e1  input  DW  SHALL carry the even-part coefficient of the current pair.
REQ-007 o1  input  DW  SHALL carry the odd-part coefficient of the current pair.
REQ-008 out_valid  output  1  SHALL indicate that x is valid.
REQ-009 out_ready  input  1  SHALL indicate that the downstream stage accepts x this cycle.
REQ-010 x  output  DW  SHALL carry the reconstructed sample.
REQ-011 x_idx  output  3  SHALL carry the position (0..7) of x within the block.
REQ-012 x_last  output  1  SHALL be high when x_idx=7 and out_valid=1.

Function
REQ-013 The block SHALL be the inverse of the even/odd split stage: it SHALL accept 4 pairs (p=0..3) per 8-sample block and reconstruct 8 samples.
REQ-014 A pair SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-015 Accepted pair p SHALL write buf[p]=e1+o1 and buf[7-p]=e1-o1, both computed at DW+1 bits.
REQ-016 The FSM SHALL have two states: LOAD, with in_ready=1 and out_valid=0, and EMIT, with in_ready=0 and out_valid=1.
REQ-017 LOAD SHALL go to EMIT on the clock edge that accepts pair 3; EMIT SHALL go to LOAD on the edge where x_idx=7 and out_ready=1.
REQ-018 out_valid SHALL assert in the cycle immediately after pair 3 is accepted (latency 1 cycle).
REQ-019 In EMIT, x SHALL equal buf[x_idx], and x_idx SHALL start at 0 and increment only when out_ready=1.
REQ-020 While out_ready=0, x, x_idx and x_last SHALL hold stable.
REQ-021 The pair counter SHALL wrap 3->0 on the transition to EMIT, and x_idx SHALL wrap 7->0 on the transition to LOAD.
REQ-022 The block SHALL not overlap blocks: pairs presented during EMIT SHALL not be accepted and SHALL remain pending upstream.
REQ-023 in_valid gaps in LOAD SHALL stall the pair counter without loss of already-buffered pairs.

Reset
REQ-024 While rst=1, the state SHALL be LOAD, the pair counter 0, x_idx 0, and all buf entries 0.
REQ-025 While rst=1, out_valid=0, x=0 and x_last=0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-026 rst asserted mid-LOAD or mid-EMIT SHALL discard the partial block, and no stale sample SHALL be emitted afterwards.
REQ-027 rst SHALL take priority over a simultaneous handshake in the same cycle.

Configuration
REQ-028 With macro IDCT_SAT_EN defined, each DW+1-bit buf result SHALL saturate to the signed DW range: -128..127 for DW=8.
REQ-029 Without IDCT_SAT_EN, each result SHALL be truncated to its low DW bits (two's-complement wrap).

Verification
REQ-030 After rst, feed pairs (e1,o1)=(10,2),(20,-3),(-5,5),(0,0) with out_ready=1 -> x sequence 12,17,0,0,0,-10,23,8; x_last only on the 8th sample; out_valid is first high 1 cycle after pair 3.
REQ-031 Block with pair 0 = (100,100), built with IDCT_SAT_EN -> x[0]=127; the same block built without IDCT_SAT_EN -> x[0]=-56.
REQ-032 Hold out_ready=0 for 5 cycles at x_idx=3 -> x and x_idx are stable; in_ready=0 throughout even with in_valid=1; emission resumes at x_idx=3.
REQ-033 Assert rst for 1 cycle after 2 pairs accepted, then send a full new block -> output matches the new block only.
REQ-034 Send 3 back-to-back blocks with random in_valid/out_ready gaps -> output matches a reference model with no sample dropped or duplicated.
